// File: rtl/ansi_pkg.sv
// Shared opcodes, parser state encoding and character constants for the ANSI/VT100 decoder.
package ansi_pkg;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_PUTC = 4'd1;
    localparam logic [3:0] OP_CR   = 4'd2;
    localparam logic [3:0] OP_LF   = 4'd3;
    localparam logic [3:0] OP_BS   = 4'd4;
    localparam logic [3:0] OP_TAB  = 4'd5;
    localparam logic [3:0] OP_CUU  = 4'd6;
    localparam logic [3:0] OP_CUD  = 4'd7;
    localparam logic [3:0] OP_CUF  = 4'd8;
    localparam logic [3:0] OP_CUB  = 4'd9;
    localparam logic [3:0] OP_CUP  = 4'd10;
    localparam logic [3:0] OP_ED   = 4'd11;
    localparam logic [3:0] OP_EL   = 4'd12;
    localparam logic [3:0] OP_SGR  = 4'd13;

    typedef enum logic [1:0] {
        ST_GROUND = 2'd0,
        ST_ESC    = 2'd1,
        ST_CSI    = 2'd2
    } state_e;

    localparam logic [7:0] CH_ESC   = 8'h1B;
    localparam logic [7:0] CH_CSI   = 8'h5B;
    localparam logic [7:0] CH_CAN   = 8'h18;
    localparam logic [7:0] CH_SUB   = 8'h1A;
    localparam logic [7:0] CH_SEMI  = 8'h3B;
    localparam logic [7:0] CH_QMARK = 8'h3F;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_TAB   = 8'h09;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= 8'h30) && (b <= 8'h39);
    endfunction

    // Cursor counts and positions treat an absent or zero parameter as 1.
    function automatic logic [7:0] one_if_zero(input logic present, input logic [7:0] v);
        logic [7:0] r;
        if (!present || (v == 8'd0)) begin
            r = 8'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/ansi_parser_if.sv
// Byte-in / command-out port bundle of the ANSI decoder.
// master = decoder side, slave = byte source plus screen-update consumer.
interface ansi_parser_if;
    logic [7:0] data;
    logic       complete;
    logic       cmd_valid;
    logic [3:0] cmd_op;
    logic [7:0] cmd_char;
    logic [7:0] cmd_arg0;
    logic [7:0] cmd_arg1;
    logic       cmd_ready;
    logic       overrun;

    modport master (
        input  data, complete, cmd_ready,
        output cmd_valid, cmd_op, cmd_char, cmd_arg0, cmd_arg1, overrun
    );

    modport slave (
        output data, complete, cmd_ready,
        input  cmd_valid, cmd_op, cmd_char, cmd_arg0, cmd_arg1, overrun
    );
endinterface

// File: rtl/ansi_param_acc.sv
// Saturating decimal accumulator for one CSI numeric parameter slot.
module ansi_param_acc #(
    parameter int unsigned PARAM_MAX = 32'd255
) (
    input  logic       clk100,
    input  logic       reset,
    input  logic       clr,
    input  logic       digit_en,
    input  logic [3:0] digit,
    output logic [7:0] value,
    output logic       present
);

    localparam logic [11:0] MAX_W = 12'(PARAM_MAX);
    localparam logic [7:0]  MAX_B = 8'(PARAM_MAX);

    logic [7:0]  value_q, value_d;
    logic        present_q, present_d;
    logic [11:0] prod_s;

    // Next value: clear, or value*10+digit clamped to PARAM_MAX (2559 worst case fits 12 bits).
    always_comb begin
        prod_s    = ({4'd0, value_q} * 12'd10) + {8'd0, digit};
        value_d   = value_q;
        present_d = present_q;
        if (clr) begin
            value_d   = 8'd0;
            present_d = 1'b0;
        end else if (digit_en) begin
            present_d = 1'b1;
            if (prod_s > MAX_W) begin
                value_d = MAX_B;
            end else begin
                value_d = prod_s[7:0];
            end
        end else begin
            value_d   = value_q;
            present_d = present_q;
        end
    end

    // Accumulator registers.
    always_ff @(posedge clk100) begin
        if (reset) begin
            value_q   <= 8'd0;
            present_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            present_q <= present_d;
        end
    end

    assign value   = value_q;
    assign present = present_q;

endmodule

// File: rtl/ansi_parser.sv
// ANSI/VT100 escape-sequence decoder: UART byte strobes in, one terminal command per recognised input out.
// Optional feature: define ANSI_SGR_EN to emit SGR for CSI 'm'; otherwise 'm' sequences are consumed silently.
module ansi_parser
    import ansi_pkg::*;
#(
    parameter int unsigned PARAM_MAX = 32'd255
) (
    input  logic            clk100,
    input  logic            reset,
    ansi_parser_if.master   bus
);

    state_e     state_q, state_d;
    logic [1:0] idx_q, idx_d;
    logic       priv_q, priv_d;
    logic       seen_q, seen_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [3:0] cmd_op_q, cmd_op_d;
    logic [7:0] cmd_char_q, cmd_char_d;
    logic [7:0] cmd_arg0_q, cmd_arg0_d;
    logic [7:0] cmd_arg1_q, cmd_arg1_d;
    logic       overrun_q, overrun_d;

    logic       byte_acc_s, drop_s;
    logic       acc_clr_s;
    logic [1:0] acc_en_s;
    logic [7:0] p0_val_s, p1_val_s;
    logic       p0_pres_s, p1_pres_s;

    logic       fin_emit_s;
    logic [3:0] fin_op_s;
    logic [7:0] fin_a0_s, fin_a1_s;
    logic [7:0] ek_arg_s;

    logic       emit_s;
    logic [3:0] emit_op_s;
    logic [7:0] emit_char_s, emit_a0_s, emit_a1_s;

    // A byte is taken only when the output slot is free or being drained this cycle.
    assign byte_acc_s = bus.complete && (!cmd_valid_q || bus.cmd_ready);
    assign drop_s     = bus.complete && cmd_valid_q && !bus.cmd_ready;

    // Only the first two parameter slots are kept; later ones are parsed but never stored.
    ansi_param_acc #(.PARAM_MAX(PARAM_MAX)) u_p0 (
        .clk100   (clk100),
        .reset    (reset),
        .clr      (acc_clr_s),
        .digit_en (acc_en_s[0]),
        .digit    (bus.data[3:0]),
        .value    (p0_val_s),
        .present  (p0_pres_s)
    );

    ansi_param_acc #(.PARAM_MAX(PARAM_MAX)) u_p1 (
        .clk100   (clk100),
        .reset    (reset),
        .clr      (acc_clr_s),
        .digit_en (acc_en_s[1]),
        .digit    (bus.data[3:0]),
        .value    (p1_val_s),
        .present  (p1_pres_s)
    );

    // Decode of a CSI final byte against the accumulated parameters.
    always_comb begin
        fin_emit_s = 1'b0;
        fin_op_s   = OP_NOP;
        fin_a0_s   = 8'd0;
        fin_a1_s   = 8'd0;
        ek_arg_s   = p0_pres_s ? p0_val_s : 8'd0;
        if (priv_q) begin
            fin_emit_s = 1'b0;
        end else begin
            case (bus.data)
                8'h41: begin fin_emit_s = 1'b1; fin_op_s = OP_CUU; fin_a0_s = one_if_zero(p0_pres_s, p0_val_s); end
                8'h42: begin fin_emit_s = 1'b1; fin_op_s = OP_CUD; fin_a0_s = one_if_zero(p0_pres_s, p0_val_s); end
                8'h43: begin fin_emit_s = 1'b1; fin_op_s = OP_CUF; fin_a0_s = one_if_zero(p0_pres_s, p0_val_s); end
                8'h44: begin fin_emit_s = 1'b1; fin_op_s = OP_CUB; fin_a0_s = one_if_zero(p0_pres_s, p0_val_s); end
                8'h48, 8'h66: begin
                    fin_emit_s = 1'b1;
                    fin_op_s   = OP_CUP;
                    fin_a0_s   = one_if_zero(p0_pres_s, p0_val_s);
                    fin_a1_s   = one_if_zero(p1_pres_s, p1_val_s);
                end
                8'h4A, 8'h4B: begin
                    fin_emit_s = (ek_arg_s <= 8'd2);
                    fin_op_s   = (bus.data == 8'h4A) ? OP_ED : OP_EL;
                    fin_a0_s   = ek_arg_s;
                end
`ifdef ANSI_SGR_EN
                8'h6D: begin
                    fin_emit_s = 1'b1;
                    fin_op_s   = OP_SGR;
                    fin_a0_s   = p0_pres_s ? p0_val_s : 8'd0;
                    fin_a1_s   = p1_pres_s ? p1_val_s : 8'd0;
                end
`endif
                default: begin
                    fin_emit_s = 1'b0;
                end
            endcase
        end
    end

    // Parser next-state, parameter control and command emission.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        priv_d      = priv_q;
        seen_d      = seen_q;
        acc_clr_s   = 1'b0;
        acc_en_s    = 2'b00;
        emit_s      = 1'b0;
        emit_op_s   = OP_NOP;
        emit_char_s = 8'd0;
        emit_a0_s   = 8'd0;
        emit_a1_s   = 8'd0;
        if (byte_acc_s) begin
            case (state_q)
                ST_GROUND: begin
                    if ((bus.data >= 8'h20) && (bus.data <= 8'h7E)) begin
                        emit_s      = 1'b1;
                        emit_op_s   = OP_PUTC;
                        emit_char_s = bus.data;
                    end else begin
                        case (bus.data)
                            CH_CR:   begin emit_s = 1'b1; emit_op_s = OP_CR;  end
                            CH_LF:   begin emit_s = 1'b1; emit_op_s = OP_LF;  end
                            CH_BS:   begin emit_s = 1'b1; emit_op_s = OP_BS;  end
                            CH_TAB:  begin emit_s = 1'b1; emit_op_s = OP_TAB; end
                            CH_ESC:  begin state_d = ST_ESC; end
                            default: begin state_d = ST_GROUND; end
                        endcase
                    end
                end
                ST_ESC: begin
                    if (bus.data == CH_CSI) begin
                        state_d   = ST_CSI;
                        acc_clr_s = 1'b1;
                        idx_d     = 2'd0;
                        priv_d    = 1'b0;
                        seen_d    = 1'b0;
                    end else if (bus.data == CH_ESC) begin
                        state_d = ST_ESC;
                    end else begin
                        state_d = ST_GROUND;
                    end
                end
                ST_CSI: begin
                    if (is_digit(bus.data)) begin
                        seen_d   = 1'b1;
                        acc_en_s = (idx_q == 2'd0) ? 2'b01 : ((idx_q == 2'd1) ? 2'b10 : 2'b00);
                    end else if (bus.data == CH_SEMI) begin
                        idx_d = (idx_q == 2'd2) ? 2'd2 : (idx_q + 2'd1);
                    end else if (bus.data == CH_QMARK) begin
                        priv_d = seen_q ? priv_q : 1'b1;
                    end else if ((bus.data == CH_CAN) || (bus.data == CH_SUB)) begin
                        state_d = ST_GROUND;
                    end else if (bus.data == CH_ESC) begin
                        state_d = ST_ESC;
                    end else if ((bus.data >= 8'h40) && (bus.data <= 8'h7E)) begin
                        state_d   = ST_GROUND;
                        emit_s    = fin_emit_s;
                        emit_op_s = fin_op_s;
                        emit_a0_s = fin_a0_s;
                        emit_a1_s = fin_a1_s;
                    end else begin
                        state_d = ST_CSI;
                    end
                end
                default: begin
                    state_d = ST_GROUND;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output slot: load a new command, drain on acceptance, otherwise hold; overrun is sticky.
    always_comb begin
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        cmd_char_d  = cmd_char_q;
        cmd_arg0_d  = cmd_arg0_q;
        cmd_arg1_d  = cmd_arg1_q;
        overrun_d   = overrun_q | drop_s;
        if (emit_s) begin
            cmd_valid_d = 1'b1;
            cmd_op_d    = emit_op_s;
            cmd_char_d  = emit_char_s;
            cmd_arg0_d  = emit_a0_s;
            cmd_arg1_d  = emit_a1_s;
        end else if (cmd_valid_q && bus.cmd_ready) begin
            cmd_valid_d = 1'b0;
            cmd_op_d    = OP_NOP;
            cmd_char_d  = 8'd0;
            cmd_arg0_d  = 8'd0;
            cmd_arg1_d  = 8'd0;
        end else begin
            cmd_valid_d = cmd_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q     <= ST_GROUND;
            idx_q       <= 2'd0;
            priv_q      <= 1'b0;
            seen_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= OP_NOP;
            cmd_char_q  <= 8'd0;
            cmd_arg0_q  <= 8'd0;
            cmd_arg1_q  <= 8'd0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            priv_q      <= priv_d;
            seen_q      <= seen_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_char_q  <= cmd_char_d;
            cmd_arg0_q  <= cmd_arg0_d;
            cmd_arg1_q  <= cmd_arg1_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_op    = cmd_op_q;
    assign bus.cmd_char  = cmd_char_q;
    assign bus.cmd_arg0  = cmd_arg0_q;
    assign bus.cmd_arg1  = cmd_arg1_q;
    assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_ansi_parser.sv
// Self-checking bench for ansi_parser: directed cases plus random byte streams against a
// sequence-buffering reference model. Follows ANSI_SGR_EN the same way as the design.
module tb_ansi_parser;
    import ansi_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ansi_parser_if bif();

    ansi_parser #(.PARAM_MAX(255)) dut (
        .clk100 (clk),
        .reset  (reset),
        .bus    (bif)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0 ground, 1 after ESC, 2 inside CSI; CSI bytes buffered until the final.
    int         m_mode;
    logic [7:0] m_seq[$];
    logic       exp_valid, exp_ovr;
    logic [3:0] exp_op;
    logic [7:0] exp_char, exp_a0, exp_a1;

    logic [7:0] finals[12] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h48, 8'h66,
                               8'h4A, 8'h4B, 8'h6D, 8'h68, 8'h40, 8'h7E};
    logic [7:0] ctrls[8]   = '{8'h0D, 8'h0A, 8'h08, 8'h09, 8'h18, 8'h1A, 8'h00, 8'h7F};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int clamp(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Interpret the buffered CSI body and its final byte from the sequence rules.
    function automatic void model_final(input logic [7:0] f, output bit e, output logic [3:0] op,
                                        output logic [7:0] a0, output logic [7:0] a1);
        int p[3] = '{0, 0, 0};
        int idx = 0;
        bit priv = 0;
        bit seen = 0;
        int c0, c1;
        foreach (m_seq[i]) begin
            if (m_seq[i] == 8'h3F) begin
                if (!seen) priv = 1;
            end else if (m_seq[i] == 8'h3B) begin
                idx = (idx < 2) ? idx + 1 : 2;
            end else begin
                p[idx] = clamp(p[idx] * 10 + int'(m_seq[i] - 8'h30));
                seen = 1;
            end
        end
        c0 = (p[0] == 0) ? 1 : p[0];
        c1 = (p[1] == 0) ? 1 : p[1];
        e = 0; op = OP_NOP; a0 = 8'd0; a1 = 8'd0;
        if (!priv) begin
            if (f >= 8'h41 && f <= 8'h44) begin
                e = 1; op = OP_CUU + 4'(f - 8'h41); a0 = 8'(c0);
            end else if (f == 8'h48 || f == 8'h66) begin
                e = 1; op = OP_CUP; a0 = 8'(c0); a1 = 8'(c1);
            end else if ((f == 8'h4A || f == 8'h4B) && p[0] <= 2) begin
                e = 1; op = (f == 8'h4A) ? OP_ED : OP_EL; a0 = 8'(p[0]);
`ifdef ANSI_SGR_EN
            end else if (f == 8'h6D) begin
                e = 1; op = OP_SGR; a0 = 8'(p[0]); a1 = 8'(p[1]);
`endif
            end
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b, output bit e, output logic [3:0] op,
                                       output logic [7:0] ch, output logic [7:0] a0, output logic [7:0] a1);
        e = 0; op = OP_NOP; ch = 8'd0; a0 = 8'd0; a1 = 8'd0;
        if (m_mode == 0) begin
            if (b >= 8'h20 && b <= 8'h7E) begin e = 1; op = OP_PUTC; ch = b; end
            else if (b == 8'h0D) begin e = 1; op = OP_CR; end
            else if (b == 8'h0A) begin e = 1; op = OP_LF; end
            else if (b == 8'h08) begin e = 1; op = OP_BS; end
            else if (b == 8'h09) begin e = 1; op = OP_TAB; end
            else if (b == 8'h1B) m_mode = 1;
        end else if (m_mode == 1) begin
            if (b == 8'h5B) begin m_mode = 2; m_seq.delete(); end
            else if (b != 8'h1B) m_mode = 0;
        end else begin
            if ((b >= 8'h30 && b <= 8'h39) || b == 8'h3B || b == 8'h3F) m_seq.push_back(b);
            else if (b == 8'h18 || b == 8'h1A) m_mode = 0;
            else if (b == 8'h1B) m_mode = 1;
            else if (b >= 8'h40 && b <= 8'h7E) begin
                model_final(b, e, op, a0, a1);
                m_mode = 0;
            end
        end
    endfunction

    function automatic void model_cycle(input logic c, input logic [7:0] b, input logic r);
        bit e; logic [3:0] op; logic [7:0] ch, a0, a1;
        if (reset) begin
            m_mode = 0; m_seq.delete();
            exp_valid = 0; exp_ovr = 0; exp_op = 4'd0; exp_char = 8'd0; exp_a0 = 8'd0; exp_a1 = 8'd0;
        end else if (c && exp_valid && !r) begin
            exp_ovr = 1;
        end else begin
            e = 0; op = OP_NOP; ch = 8'd0; a0 = 8'd0; a1 = 8'd0;
            if (c) model_byte(b, e, op, ch, a0, a1);
            if (e) begin
                exp_valid = 1; exp_op = op; exp_char = ch; exp_a0 = a0; exp_a1 = a1;
            end else if (exp_valid && r) begin
                exp_valid = 0; exp_op = 4'd0; exp_char = 8'd0; exp_a0 = 8'd0; exp_a1 = 8'd0;
            end
        end
    endfunction

    task automatic compare_outputs();
        check_eq("valid",   32'(bif.cmd_valid), 32'(exp_valid));
        check_eq("op",      32'(bif.cmd_op),    32'(exp_op));
        check_eq("char",    32'(bif.cmd_char),  32'(exp_char));
        check_eq("arg0",    32'(bif.cmd_arg0),  32'(exp_a0));
        check_eq("arg1",    32'(bif.cmd_arg1),  32'(exp_a1));
        check_eq("overrun", 32'(bif.overrun),   32'(exp_ovr));
    endtask

    task automatic step(input logic c, input logic [7:0] b, input logic r);
        bif.complete  = c;
        bif.data      = b;
        bif.cmd_ready = r;
        @(posedge clk);
        model_cycle(c, b, r);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic csi(input string body);
        step(1'b1, CH_ESC, 1'b1);
        step(1'b1, CH_CSI, 1'b1);
        for (int i = 0; i < body.len(); i++) step(1'b1, 8'(body[i]), 1'b1);
    endtask

    task automatic expect_cmd(input string tag, input logic [3:0] op, input logic [7:0] ch,
                              input logic [7:0] a0, input logic [7:0] a1);
        check_eq({tag, ".valid"}, 32'(bif.cmd_valid), 32'd1);
        check_eq({tag, ".op"},    32'(bif.cmd_op),    32'(op));
        check_eq({tag, ".char"},  32'(bif.cmd_char),  32'(ch));
        check_eq({tag, ".arg0"},  32'(bif.cmd_arg0),  32'(a0));
        check_eq({tag, ".arg1"},  32'(bif.cmd_arg1),  32'(a1));
    endtask

    task automatic expect_none(input string tag);
        check_eq({tag, ".valid"}, 32'(bif.cmd_valid), 32'd0);
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] r;
        case ($urandom_range(0, 9))
            0, 1:    r = CH_ESC;
            2:       r = CH_CSI;
            3:       r = 8'(8'h30 + 8'($urandom_range(0, 9)));
            4:       r = CH_SEMI;
            5:       r = finals[$urandom_range(0, 11)];
            6:       r = CH_QMARK;
            7:       r = 8'($urandom_range(32, 126));
            8:       r = ctrls[$urandom_range(0, 7)];
            default: r = 8'($urandom_range(0, 255));
        endcase
        return r;
    endfunction

    initial begin
        m_mode = 0;
        reset = 1'b1;
        bif.complete = 1'b0; bif.data = 8'd0; bif.cmd_ready = 1'b1;
        step(1'b0, 8'd0, 1'b1);
        step(1'b0, 8'd0, 1'b1);
        expect_none("reset");
        check_eq("reset.overrun", 32'(bif.overrun), 32'd0);
        reset = 1'b0;

        step(1'b1, 8'h48, 1'b1); expect_cmd("putc_H", OP_PUTC, 8'h48, 8'd0, 8'd0);
        step(1'b1, 8'h69, 1'b1); expect_cmd("putc_i", OP_PUTC, 8'h69, 8'd0, 8'd0);
        step(1'b1, CH_CR, 1'b1); expect_cmd("cr", OP_CR, 8'd0, 8'd0, 8'd0);
        step(1'b1, CH_LF, 1'b1); expect_cmd("lf", OP_LF, 8'd0, 8'd0, 8'd0);
        step(1'b0, 8'd0, 1'b1);  expect_none("drain");

        csi("12;40H");  expect_cmd("cup_12_40", OP_CUP, 8'd0, 8'd12, 8'd40);
        csi("H");       expect_cmd("cup_def", OP_CUP, 8'd0, 8'd1, 8'd1);
        csi("0C");      expect_cmd("cuf_zero", OP_CUF, 8'd0, 8'd1, 8'd0);
        csi("999A");    expect_cmd("cuu_sat", OP_CUU, 8'd0, 8'd255, 8'd0);
        csi("5J");      expect_none("ed_5");
        csi("2K");      expect_cmd("el_2", OP_EL, 8'd0, 8'd2, 8'd0);
        csi("?25h");    expect_none("private");
        csi("7;8;9f");  expect_cmd("cup_3p", OP_CUP, 8'd0, 8'd7, 8'd8);
        csi("31;1m");
`ifdef ANSI_SGR_EN
        expect_cmd("sgr", OP_SGR, 8'd0, 8'd31, 8'd1);
`else
        expect_none("sgr_off");
`endif
        step(1'b0, 8'd0, 1'b1);

        step(1'b1, 8'h61, 1'b0); expect_cmd("hold_a", OP_PUTC, 8'h61, 8'd0, 8'd0);
        step(1'b1, 8'h62, 1'b0); expect_cmd("drop_b", OP_PUTC, 8'h61, 8'd0, 8'd0);
        check_eq("overrun_set", 32'(bif.overrun), 32'd1);
        step(1'b0, 8'd0, 1'b1);  expect_none("release_a");
        check_eq("overrun_sticky", 32'(bif.overrun), 32'd1);

        csi("12");
        reset = 1'b1;
        step(1'b0, 8'd0, 1'b1);
        check_eq("in_reset.valid", 32'(bif.cmd_valid), 32'd0);
        check_eq("in_reset.op",    32'(bif.cmd_op),    32'd0);
        check_eq("in_reset.char",  32'(bif.cmd_char),  32'd0);
        check_eq("in_reset.arg0",  32'(bif.cmd_arg0),  32'd0);
        check_eq("in_reset.arg1",  32'(bif.cmd_arg1),  32'd0);
        reset = 1'b0;
        step(1'b1, 8'h41, 1'b1); expect_cmd("after_reset", OP_PUTC, 8'h41, 8'd0, 8'd0);

        for (int i = 0; i < 4000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            step(1'($urandom_range(0, 2) != 0), rand_byte(), 1'($urandom_range(0, 3) != 0));
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
